// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for syn_fifo.
// Issues chip-select/enable reads against the FIFO and re-presents the words
// as a valid/ready stream. A 2-entry buffer (head/tail) absorbs the FIFO's
// one-cycle read latency so the stream can run at one beat per cycle.
//
// Stream handshake: a beat transfers on a rising edge where o_m_valid and
// i_m_ready are both high. Once o_m_valid is raised it stays high, and
// o_m_data stays unchanged, until that transfer happens.
//
// Debug: o_dbg_occ is the buffer occupancy (0, 1 or 2 words) and o_dbg_infl
// is high while a FIFO read is outstanding.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    output logic                  o_rd_cs,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_data_out,
    input  logic                  i_empty,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [CNT_WIDTH-1:0]  o_xfer_count,
    output logic [1:0]            o_dbg_occ,
    output logic                  o_dbg_infl
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [1:0]            occ;
    logic                  infl;
    logic                  armed;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [DATA_WIDTH-1:0] buf_tail;
    logic                  pop;
    logic [2:0]            occ_sum;
    logic [1:0]            occ_next;
    logic [1:0]            cap_slot;

    // Occupancy bookkeeping and read-issue decision.
    // A read is allowed only if the words already buffered plus the one in
    // flight, minus the one leaving this cycle, leave room for one more.
    // armed keeps reads off until the first edge after reset release.
    always_comb begin
        pop      = o_m_valid & i_m_ready;
        occ_sum  = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        occ_next = occ_sum[1:0];
        cap_slot = occ - {1'b0, pop};
        o_rd_en  = i_rst_n & armed & i_enable & ~i_empty & (occ_sum < 3'd2);
        o_rd_cs  = o_rd_en;
    end

    // Control state: occupancy, outstanding-read flag, post-reset arm, beat count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            occ          <= OCC_EMPTY;
            infl         <= 1'b0;
            armed        <= 1'b0;
            o_xfer_count <= '0;
        end else begin
            occ   <= occ_next;
            infl  <= o_rd_en;
            armed <= 1'b1;
            if (pop) begin
                o_xfer_count <= o_xfer_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Two-entry data buffer: a pop shifts tail into head, and a landing read
    // word goes to the first free slot left after that shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            if (pop) begin
                buf_head <= buf_tail;
            end
            if (infl) begin
                if (cap_slot == OCC_EMPTY) begin
                    buf_head <= i_data_out;
                end else if (cap_slot == OCC_ONE) begin
                    buf_tail <= i_data_out;
                end
            end
        end
    end

    // Stream side and debug view.
    always_comb begin
        o_m_valid  = (occ != OCC_EMPTY);
        o_m_data   = buf_head;
        o_dbg_occ  = occ;
        o_dbg_infl = infl;
    end

    // OCC_TWO is the ceiling; reads stop once the buffer would reach it.
    logic unused_ok;
    assign unused_ok = (OCC_TWO == 2'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader, run with CNT_WIDTH=4 so count wrap is reachable.
// A queue-based syn_fifo model feeds the DUT; a negedge monitor records every
// accepted beat and per-cycle events; each test task compares what was
// observed with what it wrote into the FIFO.
module tb_fifo_stream_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          rd_cs, rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] xfer_count;
  logic [1:0]    dbg_occ;
  logic          dbg_infl;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .o_rd_cs(rd_cs), .o_rd_en(rd_en), .i_data_out(fifo_dout), .i_empty(fifo_empty),
    .o_m_data(m_data), .o_m_valid(m_valid), .i_m_ready(m_ready),
    .o_xfer_count(xfer_count), .o_dbg_occ(dbg_occ), .o_dbg_infl(dbg_infl)
  );

  // ---------------- syn_fifo model ----------------
  logic [DW-1:0] fifo_q[$];
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          flush_req = 1'b0;

  always @(posedge clk) begin
    if (flush_req) begin
      fifo_q.delete();
    end else begin
      if (rd_en && fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
      if (wr_req) fifo_q.push_back(wr_data);
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- monitor ----------------
  logic [DW-1:0] obs_q[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            rd_issued = 0;
  int            first_rd = -1;
  int            first_vld = -1;
  int            stall_viol = 0;
  int            occ_viol = 0;
  int            cs_viol = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      obs_q.delete();
      obs_cyc.delete();
      rd_issued  <= 0;
      first_rd   <= -1;
      first_vld  <= -1;
      stall_viol <= 0;
      occ_viol   <= 0;
      cs_viol    <= 0;
      stall_prev <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_issued <= rd_issued + 1;
        if (first_rd < 0) first_rd <= cyc;
      end
      if (m_valid && first_vld < 0) first_vld <= cyc;
      if (m_valid && m_ready) begin
        obs_q.push_back(m_data);
        obs_cyc.push_back(cyc);
      end
      if (stall_prev && !(m_valid && m_data === prev_data)) stall_viol <= stall_viol + 1;
      if (dbg_occ > 2'd2) occ_viol <= occ_viol + 1;
      if (rd_cs !== rd_en) cs_viol <= cs_viol + 1;
      stall_prev <= m_valid & ~m_ready;
      prev_data  <= m_data;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      wait_cycles(1);
      k++;
    end
    wait_cycles(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; wr_req = 1'b0; flush_req = 1'b1;
    wait_cycles(2);
    flush_req = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_req = 1'b1; wr_data = d; exp_q.push_back(d);
    wait_cycles(1);
    wr_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    m_ready = 1'b1;
    push_word(8'h5A); push_word(8'h5B); push_word(8'h5C);
    wait_cycles(2);
    rst_n = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cycles(1);
      checks++;
      if (rd_en !== 1'b0 || rd_cs !== 1'b0)
        begin errors++; $display("FAIL reset_rd_en cycle %0d got rd_en=%b rd_cs=%b expected 0", i, rd_en, rd_cs); end
    end
    rst_n = 1'b1;
    #2;
    checks++;
    if (m_valid !== 1'b0 || xfer_count !== '0 || m_data !== '0)
      begin errors++; $display("FAIL reset_outputs got valid=%b count=%0d data=%h expected 0/0/00", m_valid, xfer_count, m_data); end
    checks++;
    if (rd_en !== 1'b0)
      begin errors++; $display("FAIL reset_first_cycle got rd_en=%b expected 0", rd_en); end
    enable = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    m_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    wait_cycles(2);
    enable = 1'b1;
    wait_beats(3, 30);
    checks++;
    if (obs_q.size() != 3)
      begin errors++; $display("FAIL basic_beats got %0d expected 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL basic_data[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (first_vld != first_rd + 2)
      begin errors++; $display("FAIL basic_latency got valid at %0d expected %0d", first_vld, first_rd + 2); end
    checks++;
    if (obs_cyc.size() == 3 && obs_cyc[2] - obs_cyc[0] != 2)
      begin errors++; $display("FAIL basic_throughput got span %0d expected 2", obs_cyc[2] - obs_cyc[0]); end
    checks++;
    if (xfer_count !== 4'd3 || fifo_empty !== 1'b1 || rd_en !== 1'b0 || m_valid !== 1'b0)
      begin errors++; $display("FAIL basic_end got count=%0d empty=%b rd_en=%b valid=%b expected 3/1/0/0", xfer_count, fifo_empty, rd_en, m_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    wait_cycles(10);
    checks++;
    if (rd_issued != 2)
      begin errors++; $display("FAIL bp_reads got %0d expected 2", rd_issued); end
    checks++;
    if (dbg_occ !== 2'd2 || m_valid !== 1'b1 || m_data !== 8'hA0)
      begin errors++; $display("FAIL bp_hold got occ=%0d valid=%b data=%h expected 2/1/a0", dbg_occ, m_valid, m_data); end
    m_ready = 1'b1;
    wait_beats(8, 40);
    checks++;
    if (obs_q.size() != 8)
      begin errors++; $display("FAIL bp_beats got %0d expected 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL bp_data[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (obs_cyc.size() == 8 && obs_cyc[7] - obs_cyc[0] != 7)
      begin errors++; $display("FAIL bp_throughput got span %0d expected 7", obs_cyc[7] - obs_cyc[0]); end
    checks++;
    if (xfer_count !== 4'd8)
      begin errors++; $display("FAIL bp_count got %0d expected 8", xfer_count); end
  endtask

  task automatic test_random();
    int written = 0;
    int k = 0;
    do_reset();
    enable = 1'b1;
    while ((written < 200 || obs_q.size() < 200) && k < 4000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (written < 200 && $urandom_range(0, 3) != 0) begin
        wr_req = 1'b1; wr_data = 8'($urandom); exp_q.push_back(wr_data); written++;
      end else begin
        wr_req = 1'b0;
      end
      wait_cycles(1);
      k++;
    end
    wr_req = 1'b0;
    m_ready = 1'b1;
    wait_cycles(4);
    checks++;
    if (obs_q.size() != 200)
      begin errors++; $display("FAIL rand_beats got %0d expected 200", obs_q.size()); end
    for (int i = 0; i < 200 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i])
        begin errors++; $display("FAIL rand_data[%0d] got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (stall_viol != 0 || occ_viol != 0 || cs_viol != 0)
      begin errors++; $display("FAIL rand_rules got stall=%0d occ=%0d cs=%0d expected 0", stall_viol, occ_viol, cs_viol); end
    checks++;
    if (xfer_count !== 4'(200 % 16))
      begin errors++; $display("FAIL rand_count got %0d expected %0d", xfer_count, 200 % 16); end
  endtask

  task automatic test_enable_drop();
    int k = 0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    enable = 1'b1;
    while (rd_issued == 0 && k < 20) begin wait_cycles(1); k++; end
    enable = 1'b0;
    wait_cycles(10);
    checks++;
    if (rd_issued != 1 || obs_q.size() != 1 || fifo_q.size() != 3)
      begin errors++; $display("FAIL en_drop got reads=%0d beats=%0d left=%0d expected 1/1/3", rd_issued, obs_q.size(), fifo_q.size()); end
    checks++;
    if (obs_q.size() > 0 && obs_q[0] !== 8'hC0)
      begin errors++; $display("FAIL en_drop_data got %h expected c0", obs_q[0]); end
    enable = 1'b1;
    wait_beats(4, 30);
    checks++;
    if (obs_q.size() != 4 || obs_q[3] !== 8'hC3 || xfer_count !== 4'd4)
      begin errors++; $display("FAIL en_resume got beats=%0d count=%0d expected 4/4", obs_q.size(), xfer_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    m_ready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'($urandom));
    wait_beats(17, 40);
    checks++;
    if (obs_q.size() != 17)
      begin errors++; $display("FAIL wrap_beats got %0d expected 17", obs_q.size()); end
    checks++;
    if (xfer_count !== 4'd1)
      begin errors++; $display("FAIL wrap_count got %0d expected 1", xfer_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_enable_drop();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
